// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide engine.
// Shift-add multiply and restoring divide, one bit per clock, WIDTH clocks
// per operation, HI/LO results, start/done handshake.
// Optional feature: define MULDIV_ABORT_EN to add an abort input that
// cancels an operation in progress without touching hi/lo.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t               state, state_nxt;
    logic                 is_div_q, dz_q, neg_res_q, neg_rem_q;
    logic [WIDTH-1:0]     mag_b_q;
    logic [2*WIDTH-1:0]   acc_q, acc_nxt;
    logic [CW-1:0]        cnt_q;

    logic                 is_signed_in, is_div_in, b_zero, last_iter, abort_hit;
    logic [WIDTH-1:0]     mag_a_in, mag_b_in;
    logic [WIDTH:0]       add_sum;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_sub;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign is_signed_in = ~op[0];
    assign is_div_in    = op[1];
    assign b_zero       = (b == '0);
    assign mag_a_in     = (is_signed_in && a[WIDTH-1]) ? -a : a;
    assign mag_b_in     = (is_signed_in && b[WIDTH-1]) ? -b : b;
    assign last_iter    = (cnt_q == CW'(WIDTH - 1));

`ifdef MULDIV_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // One iteration step; acc holds {partial, multiplier} or {remainder, quotient}
    always_comb begin
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_b_q : {WIDTH{1'b0}})};
        rem_ge  = (acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, mag_b_q});
        rem_sub = acc_q[2*WIDTH-2:WIDTH-1] - mag_b_q;
        if (is_div_q) begin
            if (rem_ge)
                acc_nxt = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {add_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction of the final magnitudes
    always_comb begin
        prod_fix = neg_res_q ? -acc_nxt : acc_nxt;
        quo_fix  = neg_res_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (is_div_in && b_zero) ? DONE : ITER;
            ITER: begin
                if (abort_hit)
                    state_nxt = IDLE;
                else if (last_iter)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        div_zero = (state == DONE) && dz_q;
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div_q  <= is_div_in;
                        dz_q      <= is_div_in && b_zero;
                        neg_res_q <= is_signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_q <= is_signed_in && a[WIDTH-1];
                        mag_b_q   <= mag_b_in;
                        acc_q     <= {{WIDTH{1'b0}}, mag_a_in};
                        cnt_q     <= '0;
                    end
                end
                ITER: begin
                    if (!abort_hit) begin
                        acc_q <= acc_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_iter) begin
                            if (is_div_q) begin
                                hi <= rem_fix;
                                lo <= quo_fix;
                            end else begin
                                hi <= prod_fix[2*WIDTH-1:WIDTH];
                                lo <= prod_fix[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH=32): arithmetic reference model plus
// directed vectors with literal expectations.
module tb_muldiv_unit;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        op = 2'b00;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic [WIDTH-1:0]  hi, lo;
    logic              busy, done, div_zero;
`ifdef MULDIV_ABORT_EN
    logic              abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start),
        .op       (op),
`ifdef MULDIV_ABORT_EN
        .abort    (abort),
`endif
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference arithmetic with 64-bit integers
    function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] h, output logic [31:0] l, output logic z);
        longint sx, sy, p, q, r;
        logic [63:0] up;
        z = 1'b0; h = '0; l = '0;
        case (o)
            2'b00: begin
                sx = $signed(x); sy = $signed(y); p = sx * sy;
                h = p[63:32]; l = p[31:0];
            end
            2'b01: begin
                up = {32'b0, x} * {32'b0, y};
                h = up[63:32]; l = up[31:0];
            end
            2'b10: begin
                if (y == 0) z = 1'b1;
                else begin
                    sx = $signed(x); sy = $signed(y); q = sx / sy; r = sx % sy;
                    l = q[31:0]; h = r[31:0];
                end
            end
            default: begin
                if (y == 0) z = 1'b1;
                else begin
                    l = x / y; h = x % y;
                end
            end
        endcase
    endfunction

    // Timeline model: cycles remaining until idle, pending result
    int          m_rem = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_pdz = 1'b0;
    logic        m_ab;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_hi = '0; m_lo = '0; m_pdz = 1'b0;
        end else if (m_rem == 0) begin
            if (start) begin
                model_op(op, a, b, p_hi, p_lo, m_pdz);
                m_rem = m_pdz ? 1 : WIDTH + 1;
            end
        end else begin
            m_ab = 1'b0;
`ifdef MULDIV_ABORT_EN
            m_ab = abort;
`endif
            if (m_ab && m_rem > 1) begin
                m_rem = 0;
            end else begin
                m_rem--;
                if (m_rem == 1 && !m_pdz) begin
                    m_hi = p_hi; m_lo = p_lo;
                end
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        check("busy", busy, m_rem != 0);
        check("done", done, m_rem == 1);
        check("div_zero", div_zero, (m_rem == 1) && m_pdz);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input int elat, input string nm);
        int lat;
        @(negedge clk);
        op = o; a = ia; b = ib; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_done"}, done, 1'b1);
        check({nm, "_lat"}, lat, elat);
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
        check({nm, "_dz"}, div_zero, edz);
        @(negedge clk);
    endtask

    task automatic run_rand(input int idx);
        int n;
        @(negedge clk);
        op = 2'($urandom_range(0, 3)); a = $urandom; b = (idx == 5) ? '0 : $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rand_finish", n < 100, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n_done, lat;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        rst_n = 1'b1;

        run_op(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32, "mult_neg3x7");
        run_op(2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 32, "multu_max_x2");
        run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32, "div_neg7_2");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32, "div_min_neg1");
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 32, "mult_neg1sq");
        run_op(2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32, "div_7_neg2");
        run_op(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 32, "divu_100_7");
        run_op(2'b11, 32'h2211,     32'h100,      32'h11,       32'h22,       1'b0, 32, "divu_prep");
        run_op(2'b11, 32'd5,        32'd0,        32'h11,       32'h22,       1'b1, 0,  "divu_by_zero");

        // start pulsed again mid-operation is ignored
        @(negedge clk);
        op = 2'b01; a = 32'hFFFFFFFF; b = 32'd2; start = 1'b1;
        n_done = 0; lat = -1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 9) begin start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1; end
            if (k == 10) start = 1'b0;
            if (done) begin
                n_done++;
                if (lat < 0) begin
                    lat = k;
                    check("repulse_hi", hi, 32'h00000001);
                    check("repulse_lo", lo, 32'hFFFFFFFE);
                end
            end
        end
        check("repulse_ndone", n_done, 1);
        check("repulse_lat", lat, 32);

        for (int i = 0; i < 6; i++) run_rand(i);

        // asynchronous reset in the middle of an operation
        run_op(2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 32, "multu_pre_rst");
        @(negedge clk);
        op = 2'b00; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_dz", div_zero, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32, "mult_after_rst");

`ifdef MULDIV_ABORT_EN
        // abort during ITER: no done, hi/lo untouched
        @(negedge clk);
        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        n_done = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 11) abort = 1'b1;
            if (k == 12) begin
                abort = 1'b0;
                check("abort_busy", busy, 0);
            end
            if (done) n_done++;
        end
        check("abort_ndone", n_done, 0);
        check("abort_hi", hi, 32'hFFFFFFFF);
        check("abort_lo", lo, 32'hFFFFFFEB);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
